// File: rtl/huff_seq.sv
// Frame sequencer around a Huffman decoder core: parses a symbol-count header,
// forwards payload bits to the decoder and buffers decoded symbols in a small FIFO.
module huff_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int HDR_BITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       serial_in,
  input  logic       serial_valid,
  output logic       dec_bit,
  output logic       dec_bit_valid,
  output logic       dec_clear,
  input  logic       dec_sym_valid,
  input  logic [7:0] dec_sym,
  output logic       externalEn,
  output logic [7:0] externalChar,
  input  logic       externalReady,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic [1:0] state_dbg
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int HCW = $clog2(HDR_BITS + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DECODE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [HDR_BITS-1:0] sym_total, sym_cnt, hdr_shift, sym_cnt_inc;
  logic [HCW-1:0]      hdr_cnt;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic fifo_empty, fifo_full, pop, push_req, push;
  logic start_acc, hdr_last, last_sym, fwd;

  // Output handshake: a symbol transfers on every rising edge where
  // externalEn and externalReady are both high; externalChar holds until then.
  always_comb begin
    hdr_shift   = {sym_total[HDR_BITS-2:0], serial_in};
    sym_cnt_inc = sym_cnt + HDR_BITS'(1);
    start_acc   = (state == IDLE) && start;
    hdr_last    = (state == HEADER) && serial_valid && (hdr_cnt == HCW'(HDR_BITS - 1));
    push_req    = (state == DECODE) && dec_sym_valid;
    last_sym    = push_req && (sym_cnt_inc == sym_total);
    fwd         = (state == DECODE) && serial_valid && !last_sym;
    fifo_empty  = (wr_ptr == rd_ptr);
    fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    externalEn  = !fifo_empty;
    pop         = externalEn && externalReady;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push        = push_req && (!fifo_full || pop);
    externalChar = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    busy        = (state != IDLE);
    done        = (state == DRAIN) && fifo_empty;
    state_dbg   = state;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HEADER;
      HEADER:  if (hdr_last) state_nxt = (hdr_shift == '0) ? DRAIN : DECODE;
      DECODE:  if (last_sym) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_clear     <= 1'b0;
      dec_bit       <= 1'b0;
      dec_bit_valid <= 1'b0;
      sym_total     <= '0;
      sym_cnt       <= '0;
      hdr_cnt       <= '0;
      overflow      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      dec_clear     <= start_acc;
      dec_bit_valid <= fwd;
      dec_bit       <= fwd & serial_in;
      if (start_acc) begin
        sym_total <= '0;
        sym_cnt   <= '0;
        hdr_cnt   <= '0;
        overflow  <= 1'b0;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end else begin
        if ((state == HEADER) && serial_valid) begin
          sym_total <= hdr_shift;
          hdr_cnt   <= hdr_cnt + HCW'(1);
        end
        if (push_req)         sym_cnt  <= sym_cnt_inc;
        if (push_req && !push) overflow <= 1'b1;
        if (push)             wr_ptr   <= wr_ptr + (AW+1)'(1);
        if (pop)              rd_ptr   <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dec_sym;
  end

endmodule

// File: tb/tb_huff_seq.sv
// Directed bench for huff_seq: frames with hand-computed symbol streams,
// overflow, full-FIFO pass-through, ignored start and mid-frame reset.
module tb_huff_seq;

  logic       clk, rst, start, serial_in, serial_valid;
  logic       dec_bit, dec_bit_valid, dec_clear;
  logic       dec_sym_valid;
  logic [7:0] dec_sym;
  logic       externalEn;
  logic [7:0] externalChar;
  logic       externalReady;
  logic       busy, done, overflow;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int done_cnt, dbv_cnt, en_cnt;

  huff_seq #(.FIFO_DEPTH(4), .HDR_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .serial_in(serial_in),
    .serial_valid(serial_valid), .dec_bit(dec_bit), .dec_bit_valid(dec_bit_valid),
    .dec_clear(dec_clear), .dec_sym_valid(dec_sym_valid), .dec_sym(dec_sym),
    .externalEn(externalEn), .externalChar(externalChar),
    .externalReady(externalReady), .busy(busy), .done(done),
    .overflow(overflow), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (externalEn && externalReady) got_q.push_back(externalChar);
    if (done) done_cnt++;
    if (dec_bit_valid) dbv_cnt++;
    if (externalEn) en_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    dbv_cnt  = 0;
    en_cnt   = 0;
  endtask

  task automatic do_start(input logic [7:0] h);
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (dec_clear !== 1'b1 || busy !== 1'b1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL start_accept clear=%b busy=%b ovf=%b, want 1 1 0", dec_clear, busy, overflow);
    end
    for (int i = 7; i >= 0; i--) begin
      serial_in    = h[i];
      serial_valid = 1'b1;
      tick();
      if (i == 7) begin
        tests++;
        if (dec_clear !== 1'b0) begin
          fails++;
          $display("FAIL clear_pulse_width got %b want 0", dec_clear);
        end
      end
    end
    serial_valid = 1'b0;
    serial_in    = 1'b0;
    tests++;
    if (dbv_cnt != 0) begin
      fails++;
      $display("FAIL header_not_forwarded dec_bit_valid cycles=%0d want 0", dbv_cnt);
    end
  endtask

  task automatic push_sym(input logic [7:0] v);
    dec_sym       = v;
    dec_sym_valid = 1'b1;
    tick();
    dec_sym_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (state_dbg !== 2'd0 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL %s_timeout state=%0d want 0", name, state_dbg);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || externalEn !== 1'b0 ||
        externalChar !== 8'h00 || dec_bit !== 1'b0 || dec_bit_valid !== 1'b0 ||
        dec_clear !== 1'b0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL reset_values busy=%b done=%b ovf=%b en=%b ch=%h db=%b dbv=%b clr=%b st=%0d, want all 0",
               busy, done, overflow, externalEn, externalChar, dec_bit, dec_bit_valid, dec_clear, state_dbg);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clear_mon();
    externalReady = 1'b1;
    do_start(8'h03);
    tests++;
    if (state_dbg !== 2'd2) begin
      fails++;
      $display("FAIL basic_decode_state got %0d want 2", state_dbg);
    end
    serial_in = 1'b1; serial_valid = 1'b1;
    tick();
    tests++;
    if (dec_bit_valid !== 1'b1 || dec_bit !== 1'b1) begin
      fails++;
      $display("FAIL fwd_bit1 got v=%b b=%b want 1 1", dec_bit_valid, dec_bit);
    end
    serial_in = 1'b0;
    tick();
    tests++;
    if (dec_bit_valid !== 1'b1 || dec_bit !== 1'b0) begin
      fails++;
      $display("FAIL fwd_bit0 got v=%b b=%b want 1 0", dec_bit_valid, dec_bit);
    end
    serial_valid = 1'b0;
    tick();
    tests++;
    if (dec_bit_valid !== 1'b0) begin
      fails++;
      $display("FAIL fwd_idle got v=%b want 0", dec_bit_valid);
    end
    push_sym(8'h41);
    push_sym(8'h42);
    serial_in = 1'b1; serial_valid = 1'b1;
    push_sym(8'h43);
    tests++;
    if (dec_bit_valid !== 1'b0 || state_dbg !== 2'd3) begin
      fails++;
      $display("FAIL basic_after_last got v=%b st=%0d want 0 3", dec_bit_valid, state_dbg);
    end
    tick();
    tests++;
    if (dec_bit_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain_no_fwd got v=%b want 0", dec_bit_valid);
    end
    serial_valid = 1'b0; serial_in = 1'b0;
    wait_idle("basic");
    exp_q = '{8'h41, 8'h42, 8'h43};
    tests++;
    if (got_q.size() != exp_q.size() || done_cnt != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_summary got n=%0d done=%0d busy=%b want 3 1 0", got_q.size(), done_cnt, busy);
    end
    foreach (exp_q[i]) begin
      tests++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL basic_sym%0d got %h want %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_header();
    clear_mon();
    do_start(8'h00);
    tests++;
    if (state_dbg !== 2'd3 || done !== 1'b1) begin
      fails++;
      $display("FAIL zero_drain got st=%0d done=%b want 3 1", state_dbg, done);
    end
    repeat (2) tick();
    tests++;
    if (done_cnt != 1 || dbv_cnt != 0 || en_cnt != 0 || state_dbg !== 2'd0) begin
      fails++;
      $display("FAIL zero_frame got done=%0d dbv=%0d en=%0d st=%0d want 1 0 0 0",
               done_cnt, dbv_cnt, en_cnt, state_dbg);
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    externalReady = 1'b0;
    do_start(8'h06);
    for (int i = 0; i < 6; i++) push_sym(8'h10 + 8'(i));
    tests++;
    if (overflow !== 1'b1 || state_dbg !== 2'd3 || externalEn !== 1'b1 || externalChar !== 8'h10) begin
      fails++;
      $display("FAIL ovf_state got ovf=%b st=%0d en=%b ch=%h want 1 3 1 10",
               overflow, state_dbg, externalEn, externalChar);
    end
    repeat (2) tick();
    tests++;
    if (externalChar !== 8'h10 || got_q.size() != 0) begin
      fails++;
      $display("FAIL ovf_hold got ch=%h pops=%0d want 10 0", externalChar, got_q.size());
    end
    externalReady = 1'b1;
    wait_idle("ovf");
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    tests++;
    if (got_q.size() != 4 || done_cnt != 1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL ovf_summary got n=%0d done=%0d ovf=%b want 4 1 1", got_q.size(), done_cnt, overflow);
    end
    foreach (exp_q[i]) begin
      tests++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ovf_sym%0d got %h want %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_full_pop();
    clear_mon();
    externalReady = 1'b0;
    do_start(8'h05);
    for (int i = 0; i < 4; i++) push_sym(8'h20 + 8'(i));
    externalReady = 1'b1;
    push_sym(8'h24);
    tests++;
    if (overflow !== 1'b0 || state_dbg !== 2'd3) begin
      fails++;
      $display("FAIL full_pop_push got ovf=%b st=%0d want 0 3", overflow, state_dbg);
    end
    wait_idle("full_pop");
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    tests++;
    if (got_q.size() != 5 || done_cnt != 1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_pop_summary got n=%0d done=%0d ovf=%b want 5 1 0", got_q.size(), done_cnt, overflow);
    end
    foreach (exp_q[i]) begin
      tests++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL full_pop_sym%0d got %h want %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    clear_mon();
    externalReady = 1'b1;
    do_start(8'h02);
    push_sym(8'h30);
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++;
    if (dec_clear !== 1'b0 || state_dbg !== 2'd2) begin
      fails++;
      $display("FAIL start_ignored got clr=%b st=%0d want 0 2", dec_clear, state_dbg);
    end
    push_sym(8'h31);
    wait_idle("start_ign");
    exp_q = '{8'h30, 8'h31};
    tests++;
    if (got_q.size() != 2 || done_cnt != 1) begin
      fails++;
      $display("FAIL start_ign_summary got n=%0d done=%0d want 2 1", got_q.size(), done_cnt);
    end
    foreach (exp_q[i]) begin
      tests++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL start_ign_sym%0d got %h want %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    externalReady = 1'b0;
    do_start(8'h05);
    push_sym(8'h50);
    push_sym(8'h51);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (externalEn !== 1'b0 || externalChar !== 8'h00 || busy !== 1'b0 || state_dbg !== 2'd0 ||
        overflow !== 1'b0 || done !== 1'b0 || dec_clear !== 1'b0 || dec_bit_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got en=%b ch=%h busy=%b st=%0d ovf=%b done=%b clr=%b dbv=%b, want all 0",
               externalEn, externalChar, busy, state_dbg, overflow, done, dec_clear, dec_bit_valid);
    end
    #2 rst = 1'b0;
    repeat (3) tick();
    tests++;
    if (state_dbg !== 2'd0 || externalEn !== 1'b0) begin
      fails++;
      $display("FAIL reset_wait got st=%0d en=%b want 0 0", state_dbg, externalEn);
    end
    clear_mon();
    externalReady = 1'b1;
    do_start(8'h01);
    push_sym(8'h60);
    wait_idle("post_reset");
    tests++;
    if (got_q.size() != 1 || done_cnt != 1 || (got_q.size() == 1 && got_q[0] !== 8'h60)) begin
      fails++;
      $display("FAIL post_reset_frame got n=%0d done=%0d first=%h want 1 1 60",
               got_q.size(), done_cnt, (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; serial_in = 1'b0; serial_valid = 1'b0;
    dec_sym_valid = 1'b0; dec_sym = 8'h00; externalReady = 1'b0;
    clear_mon();
    #1;
    test_reset();
    test_basic();
    test_zero_header();
    test_overflow();
    test_full_pop();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
